parity_encoder: RTL and testbench

PARITY_ENCODER -- requirements
Module: parity_encoder

---
 rtl/parity_encoder.sv | 152 +++++++++++++++
 tb/tb_parity_encoder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_encoder.sv
`timescale 1ns/1ps
// Two-entry skid buffer that stores even parity with each byte/instruction word; PARITY_ERR_INJECT_EN adds one-shot parity corruption.
// Latency: a word accepted on an edge is presented with out_valid on the following cycle.
// Backpressure: in_ready is registered state only; it drops when both the output and skid registers are full.
module parity_encoder #(
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable_parity,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             data_in,
    input  logic [15:0]            instruction_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0]             data_out,
    output logic                   data_parity,
    output logic [15:0]            instruction_out,
    output logic                   instruction_parity,
    output logic [COUNT_WIDTH-1:0] word_count,
    input  logic                   inject_data,
    input  logic                   inject_instr,
    output logic [COUNT_WIDTH-1:0] inject_count
);

    typedef struct packed {
        logic [7:0]  dat;
        logic        dat_par;
        logic [15:0] instr;
        logic        instr_par;
        logic        corrupt;
    } word_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t state, state_nxt;
    word_t  out_q, skid_q, in_word;
    logic   load_out_in, load_out_skid, load_skid;
    logic   in_xfer, out_xfer;
    logic   inj_data, inj_instr;

    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

`ifdef PARITY_ERR_INJECT_EN
    logic                   arm_data_q, arm_instr_q;
    logic [COUNT_WIDTH-1:0] inject_count_q;

    // A pulse coinciding with acceptance corrupts that word directly.
    assign inj_data  = arm_data_q | inject_data;
    assign inj_instr = arm_instr_q | inject_instr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            arm_data_q     <= 1'b0;
            arm_instr_q    <= 1'b0;
            inject_count_q <= '0;
        end else begin
            if (in_xfer) begin
                arm_data_q  <= 1'b0;
                arm_instr_q <= 1'b0;
            end else begin
                arm_data_q  <= inj_data;
                arm_instr_q <= inj_instr;
            end
            if (out_xfer && out_q.corrupt && (inject_count_q != '1))
                inject_count_q <= inject_count_q + 1'b1;
        end
    end

    assign inject_count = inject_count_q;
`else
    assign inj_data     = 1'b0;
    assign inj_instr    = 1'b0;
    assign inject_count = '0;

    wire unused_inject = &{1'b0, inject_data, inject_instr, out_q.corrupt};
`endif

    always_comb begin
        in_word.dat       = data_in;
        in_word.dat_par   = (enable_parity & (^data_in)) ^ inj_data;
        in_word.instr     = instruction_in;
        in_word.instr_par = (enable_parity & (^instruction_in)) ^ inj_instr;
        in_word.corrupt   = inj_data | inj_instr;
    end

    always_comb begin
        state_nxt     = state;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state)
            EMPTY: begin
                if (in_xfer) begin
                    state_nxt   = ONE;
                    load_out_in = 1'b1;
                end
            end
            ONE: begin
                case ({in_xfer, out_xfer})
                    2'b10: begin
                        state_nxt = TWO;
                        load_skid = 1'b1;
                    end
                    2'b01:   state_nxt   = EMPTY;
                    2'b11:   load_out_in = 1'b1;
                    default: state_nxt   = ONE;
                endcase
            end
            TWO: begin
                if (out_xfer) begin
                    state_nxt     = ONE;
                    load_out_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= EMPTY;
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            state <= state_nxt;
            if (load_out_in)
                out_q <= in_word;
            else if (load_out_skid)
                out_q <= skid_q;
            if (load_skid)
                skid_q <= in_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            word_count <= '0;
        else if (out_xfer && (word_count != '1))
            word_count <= word_count + 1'b1;
    end

    assign data_out           = out_q.dat;
    assign data_parity        = out_q.dat_par;
    assign instruction_out    = out_q.instr;
    assign instruction_parity = out_q.instr_par;

endmodule

// File: tb/tb_parity_encoder.sv
`timescale 1ns/1ps
// Scoreboard bench for parity_encoder: expected words queued on input transfer, compared on output transfer.
module tb_parity_encoder;

    localparam int CW = 8;
`ifdef PARITY_ERR_INJECT_EN
    localparam logic INJ = 1'b1;
`else
    localparam logic INJ = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          enable_parity;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    data_in;
    logic [15:0]   instruction_in;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    data_out;
    logic          data_parity;
    logic [15:0]   instruction_out;
    logic          instruction_parity;
    logic [CW-1:0] word_count;
    logic          inject_data;
    logic          inject_instr;
    logic [CW-1:0] inject_count;

    parity_encoder #(.COUNT_WIDTH(CW)) dut (
        .clk                (clk),
        .rst                (rst),
        .enable_parity      (enable_parity),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .data_in            (data_in),
        .instruction_in     (instruction_in),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .data_out           (data_out),
        .data_parity        (data_parity),
        .instruction_out    (instruction_out),
        .instruction_parity (instruction_parity),
        .word_count         (word_count),
        .inject_data        (inject_data),
        .inject_instr       (inject_instr),
        .inject_count       (inject_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  d;
        logic        dp;
        logic [15:0] i;
        logic        ip;
        logic        c;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    logic        arm_d, arm_i;
    int          exp_wc, exp_ic;
    logic        stall_prev = 1'b0;
    logic [25:0] held;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Inputs are stable at the falling edge, so handshakes seen here are the ones the next rising edge takes.
    always @(negedge clk) begin : monitor
        exp_t e;
        logic idd, iii;
        if (!rst) begin
            sb.delete();
            arm_d = 1'b0; arm_i = 1'b0;
            exp_wc = 0; exp_ic = 0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                check("hold", {6'd0, data_out, data_parity, instruction_out, instruction_parity}, {6'd0, held});
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("underflow", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check("word", {6'd0, data_out, data_parity, instruction_out, instruction_parity},
                          {6'd0, e.d, e.dp, e.i, e.ip});
                    check("word_count", word_count, exp_wc);
                    check("inject_count", inject_count, exp_ic);
                    if (exp_wc != 255) exp_wc++;
                    if (e.c && exp_ic != 255) exp_ic++;
                end
            end
            stall_prev = out_valid && !out_ready;
            held = {data_out, data_parity, instruction_out, instruction_parity};
            if (in_valid && in_ready) begin
                idd = INJ & (arm_d | inject_data);
                iii = INJ & (arm_i | inject_instr);
                e.d  = data_in;
                e.dp = (enable_parity & (^data_in)) ^ idd;
                e.i  = instruction_in;
                e.ip = (enable_parity & (^instruction_in)) ^ iii;
                e.c  = idd | iii;
                sb.push_back(e);
                arm_d = 1'b0; arm_i = 1'b0;
            end else begin
                arm_d = arm_d | inject_data;
                arm_i = arm_i | inject_instr;
            end
        end
    end

    task automatic push(input logic [7:0] d, input logic [15:0] i);
        int k;
        in_valid = 1'b1; data_in = d; instruction_in = i;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) check("push_timeout", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 50; k++) begin
            if (!out_valid) break;
            @(posedge clk); #1;
        end
        check("drain", out_valid, 0);
        check("sb_empty", sb.size(), 0);
    endtask

    task automatic pulse_inject(input logic d, input logic i);
        inject_data = d; inject_instr = i;
        @(posedge clk); #1;
        inject_data = 1'b0; inject_instr = 1'b0;
    endtask

    initial begin
        int t0;
        rst = 1'b0; enable_parity = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        data_in = '0; instruction_in = '0; inject_data = 1'b0; inject_instr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_data_out", data_out, 0);
        check("rst_parity", {data_parity, instruction_parity}, 0);
        check("rst_word_count", word_count, 0);
        check("rst_inject_count", inject_count, 0);
        rst = 1'b1;

        // basic parity and first-word latency
        enable_parity = 1'b1; out_ready = 1'b1;
        push(8'h07, 16'h0001);
        check("basic_out_valid", out_valid, 1);
        check("basic_dpar", data_parity, 1);
        check("basic_ipar", instruction_parity, 1);
        @(posedge clk); #1;
        check("basic_word_count", word_count, 1);
        check("basic_empty", out_valid, 0);

        // backpressure: A,B fill the buffer, C is held off
        out_ready = 1'b0;
        push(8'hA1, 16'h1234);
        check("one_in_ready", in_ready, 1);
        push(8'hB2, 16'h0F0F);
        check("two_in_ready", in_ready, 0);
        in_valid = 1'b1; data_in = 8'hC3; instruction_in = 16'h8001;
        repeat (3) @(posedge clk);
        #1;
        check("c_held_in_ready", in_ready, 0);
        check("a_at_head", data_out, 8'hA1);
        out_ready = 1'b1;
        push(8'hC3, 16'h8001);
        drain();

        // parity disabled, enable toggled while words stall
        out_ready = 1'b0; enable_parity = 1'b0;
        push(8'h01, 16'h0003);
        check("dis_dpar", data_parity, 0);
        check("dis_ipar", instruction_parity, 0);
        enable_parity = 1'b1;
        push(8'h01, 16'h0001);
        repeat (2) begin
            enable_parity = ~enable_parity;
            @(posedge clk); #1;
        end
        enable_parity = 1'b0;
        @(posedge clk); #1;
        check("dis_dpar_stable", data_parity, 0);
        out_ready = 1'b1;
        drain();

        // injection: armed pulse, repeated pulses do not stack
        enable_parity = 1'b1;
        pulse_inject(1'b1, 1'b0);
        pulse_inject(1'b1, 1'b0);
        push(8'h03, 16'h0000);
        check("inj_dpar_first", data_parity, {31'd0, INJ});
        push(8'h03, 16'h0000);
        check("inj_dpar_second", data_parity, 0);
        drain();
        check("inj_count_one", inject_count, {31'd0, INJ});

        // same-cycle instruction inject with parity disabled
        enable_parity = 1'b0;
        inject_instr = 1'b1;
        push(8'h00, 16'h0000);
        inject_instr = 1'b0;
        check("inj_ipar_same_cycle", instruction_parity, {31'd0, INJ});
        check("inj_dpar_clean", data_parity, 0);
        drain();
        check("inj_count_two", inject_count, INJ ? 32'd2 : 32'd0);

        // throughput and saturation
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        enable_parity = 1'b1; out_ready = 1'b1;
        t0 = cyc;
        for (int k = 0; k < 260; k++) push(k[7:0], 16'(k * 3));
        check("throughput", cyc - t0, 260);
        drain();
        check("wc_saturated", word_count, 255);
        push(8'h55, 16'hAAAA);
        push(8'h66, 16'h5555);
        drain();
        check("wc_holds", word_count, 255);

        // reset with two words buffered
        out_ready = 1'b0;
        push(8'h11, 16'h2222);
        push(8'h33, 16'h4444);
        check("pre_rst_full", in_ready, 0);
        rst = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_word_count", word_count, 0);
        check("mid_rst_inject_count", inject_count, 0);
        check("mid_rst_data_out", data_out, 0);
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        check("post_rst_empty", out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, checks passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
